// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pkg
// Purpose  : Shared constants and types for the ALU control decoder and the
//            multiply/divide sequencer. Holds ALU operation codes, main-decoder
//            classes, R-type funct values, mult/div op and HI/LO select types,
//            and the sequencer state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    // ALU operation codes (4-bit, zero-extended to the ALU control width)
    localparam logic [3:0] c_ALU_AND  = 4'd0;
    localparam logic [3:0] c_ALU_OR   = 4'd1;
    localparam logic [3:0] c_ALU_ADD  = 4'd2;
    localparam logic [3:0] c_ALU_SLL  = 4'd3;
    localparam logic [3:0] c_ALU_SRL  = 4'd4;
    localparam logic [3:0] c_ALU_LUI  = 4'd5;
    localparam logic [3:0] c_ALU_SUB  = 4'd6;
    localparam logic [3:0] c_ALU_SLT  = 4'd7;
    localparam logic [3:0] c_ALU_IMM8 = 4'd8;   // I-type sub-op 7
    localparam logic [3:0] c_ALU_IMM9 = 4'd9;   // I-type sub-op 8
    localparam logic [3:0] c_ALU_MFHI = 4'd10;
    localparam logic [3:0] c_ALU_MFLO = 4'd11;
    localparam logic [3:0] c_ALU_NOR  = 4'd12;
    localparam logic [3:0] c_ALU_XOR  = 4'd13;
    localparam logic [3:0] c_ALU_JR   = 4'd14;

    // Main-decoder instruction classes
    localparam logic [1:0] c_AOP_ADD   = 2'b00;
    localparam logic [1:0] c_AOP_SUB   = 2'b01;
    localparam logic [1:0] c_AOP_RTYPE = 2'b10;
    localparam logic [1:0] c_AOP_ITYPE = 2'b11;

    // R-type funct values
    localparam logic [5:0] c_FN_SLL   = 6'd0;
    localparam logic [5:0] c_FN_SRL   = 6'd2;
    localparam logic [5:0] c_FN_JR    = 6'd8;
    localparam logic [5:0] c_FN_MFHI  = 6'd16;
    localparam logic [5:0] c_FN_MFLO  = 6'd18;
    localparam logic [5:0] c_FN_MULT  = 6'd24;
    localparam logic [5:0] c_FN_MULTU = 6'd25;
    localparam logic [5:0] c_FN_DIV   = 6'd26;
    localparam logic [5:0] c_FN_DIVU  = 6'd27;
    localparam logic [5:0] c_FN_ADD   = 6'd32;
    localparam logic [5:0] c_FN_ADDU  = 6'd33;
    localparam logic [5:0] c_FN_SUB   = 6'd34;
    localparam logic [5:0] c_FN_SUBU  = 6'd35;
    localparam logic [5:0] c_FN_AND   = 6'd36;
    localparam logic [5:0] c_FN_OR    = 6'd37;
    localparam logic [5:0] c_FN_XOR   = 6'd38;
    localparam logic [5:0] c_FN_NOR   = 6'd39;
    localparam logic [5:0] c_FN_SLT   = 6'd42;
    localparam logic [5:0] c_FN_SLTU  = 6'd43;

    // Mult/div operation; the encoding equals the low two funct bits
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        HILO_NONE = 2'b00,
        HILO_HI   = 2'b01,
        HILO_LO   = 2'b10
    } hilo_sel_t;

    // Sequencer state encoding
    typedef logic [0:0] md_state_t;
    localparam md_state_t c_ST_IDLE = 1'b0;
    localparam md_state_t c_ST_RUN  = 1'b1;

    // funct 24..27 share the pattern 0110xx
    function automatic logic is_md_funct(input logic [5:0] fn);
        return (fn[5:2] == 4'b0110);
    endfunction

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_control_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_mc_if
// Purpose  : Bundles the EX-stage control inputs and the ALU control /
//            mult-div sequencing outputs of alu_control_mc.
// Ports    : i_con_AluOp, i_con_FuncCode, i_con_Other, i_con_valid,
//            i_con_flush (to decoder); o_con_AluCtrl, o_con_jumpreg,
//            o_con_illegal, o_con_hilo_sel, o_con_md_start, o_con_md_op,
//            o_con_md_busy, o_con_md_done, o_con_stall (from decoder).
//            master = pipeline side, slave = decoder side.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_control_mc_if #(
    parameter int CTRL_W  = 4,
    parameter int OTHER_W = 4
);
    logic [1:0]         i_con_AluOp;
    logic [5:0]         i_con_FuncCode;
    logic [OTHER_W-1:0] i_con_Other;
    logic               i_con_valid;
    logic               i_con_flush;

    logic [CTRL_W-1:0]  o_con_AluCtrl;
    logic               o_con_jumpreg;
    logic               o_con_illegal;
    logic [1:0]         o_con_hilo_sel;
    logic               o_con_md_start;
    logic [1:0]         o_con_md_op;
    logic               o_con_md_busy;
    logic               o_con_md_done;
    logic               o_con_stall;

    modport master (
        output i_con_AluOp, i_con_FuncCode, i_con_Other, i_con_valid, i_con_flush,
        input  o_con_AluCtrl, o_con_jumpreg, o_con_illegal, o_con_hilo_sel,
        input  o_con_md_start, o_con_md_op, o_con_md_busy, o_con_md_done, o_con_stall
    );

    modport slave (
        input  i_con_AluOp, i_con_FuncCode, i_con_Other, i_con_valid, i_con_flush,
        output o_con_AluCtrl, o_con_jumpreg, o_con_illegal, o_con_hilo_sel,
        output o_con_md_start, o_con_md_op, o_con_md_busy, o_con_md_done, o_con_stall
    );

endinterface : alu_control_mc_if
`default_nettype wire

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : md_sequencer
// Purpose  : Tracks occupancy of the multi-cycle multiply/divide unit. Issues
//            a one-cycle launch from IDLE, stays in RUN for MD_CYCLES cycles,
//            then pulses done in the first IDLE cycle. Raises stall when an
//            instruction needing the unit or HI/LO arrives while it is busy.
// Ports    : i_clk, i_rst       - clock, synchronous active-high reset
//            i_launch_req       - valid, unflushed mult/div in EX
//            i_hazard           - valid, unflushed mult/div/mfhi/mflo in EX
//            i_md_op            - decoded mult/div operation
//            o_md_start         - one-cycle launch
//            o_md_op            - operation (new op while launching)
//            o_md_busy          - unit occupied
//            o_md_done          - one-cycle completion pulse
//            o_stall            - hold IF/ID/EX
// Revision : 1.0 - initial release
// ============================================================================
module md_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    input  wire logic i_launch_req,
    input  wire logic i_hazard,
    input  md_op_t    i_md_op,
    output logic      o_md_start,
    output md_op_t    o_md_op,
    output logic      o_md_busy,
    output logic      o_md_done,
    output logic      o_stall
);

    localparam int                 c_CNT_W    = $clog2(MD_CYCLES + 1);
    // Loaded with MD_CYCLES-1 so RUN lasts exactly MD_CYCLES cycles (count reaches 0)
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    md_state_t           r_state_q, w_state_d;
    logic [c_CNT_W-1:0]  r_cnt_q,   w_cnt_d;
    md_op_t              r_md_op_q, w_md_op_d;
    logic                r_done_q,  w_done_d;
    logic                w_start;

    // Launch only from IDLE and never while reset is asserted
    assign w_start = (r_state_q == c_ST_IDLE) && i_launch_req && !i_rst;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= c_ST_IDLE;
            r_cnt_q   <= '0;
            r_md_op_q <= MD_MULT;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_md_op_q <= w_md_op_d;
            r_done_q  <= w_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_md_op_d = r_md_op_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_d = c_ST_RUN;
                    w_cnt_d   = c_CNT_LOAD;
                    w_md_op_d = i_md_op;
                end
            end
            c_ST_RUN: begin
                if (r_cnt_q == '0) begin
                    // done is registered so it lands in the first IDLE cycle
                    w_state_d = c_ST_IDLE;
                    w_done_d  = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q - c_CNT_ONE;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_md_start = w_start;
        o_md_busy  = (r_state_q == c_ST_RUN);
        // Stall holds the instruction in EX; it retries once the unit is IDLE
        o_stall    = (r_state_q == c_ST_RUN) && i_hazard;
        o_md_op    = w_start ? i_md_op : r_md_op_q;
        o_md_done  = r_done_q;
    end

endmodule : md_sequencer
`default_nettype wire

// File: rtl/alu_control_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_mc
// Purpose  : ALU control decoder with multi-cycle multiply/divide support.
//            Combinationally decodes the main-decoder class, R-type funct and
//            I-type sub-opcode into an ALU operation code, jr, illegal and
//            HI/LO select; drives the mult/div sequencer for launch and stall.
// Ports    : i_clk  - clock, rising edge
//            i_rst  - synchronous active-high reset
//            con    - alu_control_mc_if slave: i_con_AluOp, i_con_FuncCode,
//                     i_con_Other, i_con_valid, i_con_flush in; o_con_AluCtrl,
//                     o_con_jumpreg, o_con_illegal, o_con_hilo_sel,
//                     o_con_md_start, o_con_md_op, o_con_md_busy,
//                     o_con_md_done, o_con_stall out
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_mc
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W    = 4,
    parameter int OTHER_W   = 4,
    parameter int MD_CYCLES = 32
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    alu_control_mc_if.slave  con
);

    logic [3:0] w_code;
    logic       w_illegal;
    logic       w_jumpreg;
    logic       w_is_md;
    hilo_sel_t  w_hilo;
    md_op_t     w_md_op;
    logic       w_launch_req;
    logic       w_hazard;
    logic       w_md_start;
    md_op_t     w_md_op_out;
    logic       w_md_busy;
    logic       w_md_done;
    logic       w_stall;

    // Decode: every branch starts legal and falls back to illegal in default
    always_comb begin
        w_code    = 4'hF;
        w_illegal = 1'b1;
        w_jumpreg = 1'b0;
        w_hilo    = HILO_NONE;
        w_is_md   = 1'b0;
        w_md_op   = md_op_t'(con.i_con_FuncCode[1:0]);
        case (con.i_con_AluOp)
            c_AOP_ADD: begin
                w_code    = c_ALU_ADD;
                w_illegal = 1'b0;
            end
            c_AOP_SUB: begin
                w_code    = c_ALU_SUB;
                w_illegal = 1'b0;
            end
            c_AOP_RTYPE: begin
                w_illegal = 1'b0;
                case (con.i_con_FuncCode)
                    c_FN_SLL:              w_code = c_ALU_SLL;
                    c_FN_SRL:              w_code = c_ALU_SRL;
                    c_FN_JR: begin
                        w_code    = c_ALU_JR;
                        w_jumpreg = 1'b1;
                    end
                    c_FN_MFHI: begin
                        w_code = c_ALU_MFHI;
                        w_hilo = HILO_HI;
                    end
                    c_FN_MFLO: begin
                        w_code = c_ALU_MFLO;
                        w_hilo = HILO_LO;
                    end
                    c_FN_MULT, c_FN_MULTU, c_FN_DIV, c_FN_DIVU: begin
                        w_code  = c_ALU_ADD;
                        w_is_md = is_md_funct(con.i_con_FuncCode);
                    end
                    c_FN_ADD,  c_FN_ADDU:  w_code = c_ALU_ADD;
                    c_FN_SUB,  c_FN_SUBU:  w_code = c_ALU_SUB;
                    c_FN_AND:              w_code = c_ALU_AND;
                    c_FN_OR:               w_code = c_ALU_OR;
                    c_FN_XOR:              w_code = c_ALU_XOR;
                    c_FN_NOR:              w_code = c_ALU_NOR;
                    c_FN_SLT,  c_FN_SLTU:  w_code = c_ALU_SLT;
                    default:               w_illegal = 1'b1;
                endcase
            end
            c_AOP_ITYPE: begin
                w_illegal = 1'b0;
                case (con.i_con_Other)
                    OTHER_W'(0): w_code = c_ALU_ADD;
                    OTHER_W'(1): w_code = c_ALU_AND;
                    OTHER_W'(2): w_code = c_ALU_OR;
                    OTHER_W'(3): w_code = c_ALU_XOR;
                    OTHER_W'(5): w_code = c_ALU_LUI;
                    OTHER_W'(6): w_code = c_ALU_SLT;
                    OTHER_W'(7): w_code = c_ALU_IMM8;
                    OTHER_W'(8): w_code = c_ALU_IMM9;
                    default:     w_illegal = 1'b1;
                endcase
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        // Illegal encodings carry the all-ones code regardless of the branch
        if (w_illegal) begin
            w_code = 4'hF;
        end
    end

    assign w_launch_req = con.i_con_valid && !con.i_con_flush && w_is_md;
    assign w_hazard     = con.i_con_valid && !con.i_con_flush &&
                          (w_is_md || (w_hilo != HILO_NONE));

    md_sequencer #(
        .MD_CYCLES    (MD_CYCLES)
    ) u_md_seq (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_launch_req (w_launch_req),
        .i_hazard     (w_hazard),
        .i_md_op      (w_md_op),
        .o_md_start   (w_md_start),
        .o_md_op      (w_md_op_out),
        .o_md_busy    (w_md_busy),
        .o_md_done    (w_md_done),
        .o_stall      (w_stall)
    );

    // All-ones must span the full control width, not only the 4-bit code
    assign con.o_con_AluCtrl  = w_illegal ? {CTRL_W{1'b1}} : CTRL_W'(w_code);
    assign con.o_con_jumpreg  = w_jumpreg;
    assign con.o_con_illegal  = w_illegal;
    assign con.o_con_hilo_sel = w_hilo;
    assign con.o_con_md_start = w_md_start;
    assign con.o_con_md_op    = w_md_op_out;
    assign con.o_con_md_busy  = w_md_busy;
    assign con.o_con_md_done  = w_md_done;
    assign con.o_con_stall    = w_stall;

endmodule : alu_control_mc
`default_nettype wire

// File: tb/tb_alu_control_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_control_mc
// Purpose  : Directed self-checking bench for alu_control_mc: decode sweep,
//            mult/div launch timing, stall on HI/LO hazard, flush, reset
//            mid-operation and single-cycle back-to-back operation.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_control_mc;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_control_mc_if #(.CTRL_W(4), .OTHER_W(4)) bus4 ();
    alu_control_mc_if #(.CTRL_W(4), .OTHER_W(4)) bus1 ();

    alu_control_mc #(.CTRL_W(4), .OTHER_W(4), .MD_CYCLES(4)) u_dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .con   (bus4)
    );

    alu_control_mc #(.CTRL_W(4), .OTHER_W(4), .MD_CYCLES(1)) u_dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .con   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic fl, input logic [1:0] op, input logic [5:0] fn);
        bus4.i_con_valid    = v;
        bus4.i_con_flush    = fl;
        bus4.i_con_AluOp    = op;
        bus4.i_con_FuncCode = fn;
        bus4.i_con_Other    = 4'd0;
    endtask

    task automatic drive1(input logic v, input logic [5:0] fn);
        bus1.i_con_valid    = v;
        bus1.i_con_flush    = 1'b0;
        bus1.i_con_AluOp    = 2'b10;
        bus1.i_con_FuncCode = fn;
        bus1.i_con_Other    = 4'd0;
    endtask

    // Expected {AluCtrl[3:0], jumpreg, illegal, hilo_sel[1:0]} from the decode table
    function automatic logic [7:0] exp_dec(input logic [1:0] ao, input logic [5:0] fn, input logic [3:0] ot);
        logic [3:0] c;
        logic       jr;
        logic [1:0] hs;
        c  = 4'hF;
        jr = 1'b0;
        hs = 2'b00;
        if (ao == 2'b00) c = 4'd2;
        else if (ao == 2'b01) c = 4'd6;
        else if (ao == 2'b10) begin
            case (fn)
                6'd0:  c = 4'd3;
                6'd2:  c = 4'd4;
                6'd8:  begin c = 4'd14; jr = 1'b1; end
                6'd16: begin c = 4'd10; hs = 2'b01; end
                6'd18: begin c = 4'd11; hs = 2'b10; end
                6'd24, 6'd25, 6'd26, 6'd27: c = 4'd2;
                6'd32, 6'd33: c = 4'd2;
                6'd34, 6'd35: c = 4'd6;
                6'd36: c = 4'd0;
                6'd37: c = 4'd1;
                6'd38: c = 4'd13;
                6'd39: c = 4'd12;
                6'd42, 6'd43: c = 4'd7;
                default: c = 4'hF;
            endcase
        end else begin
            case (ot)
                4'd0: c = 4'd2;
                4'd1: c = 4'd0;
                4'd2: c = 4'd1;
                4'd3: c = 4'd13;
                4'd5: c = 4'd5;
                4'd6: c = 4'd7;
                4'd7: c = 4'd8;
                4'd8: c = 4'd9;
                default: c = 4'hF;
            endcase
        end
        // 0xF is never a legal code in the table, so it marks illegal
        return {c, jr, (c == 4'hF), hs};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive4(1'b0, 1'b0, 2'b00, 6'd0);
        drive1(1'b0, 6'd0);

        // Reset: decode stays input-driven, launch is gated
        cyc();
        drive4(1'b1, 1'b0, 2'b10, 6'd24);
        #1;
        check("rst_start_gated", bus4.o_con_md_start, 1'b0);
        check("rst_decode_live", bus4.o_con_AluCtrl, 4'd2);
        cyc();
        rst = 1'b0;
        drive4(1'b0, 1'b0, 2'b00, 6'd0);
        #1;
        check("reset_busy", bus4.o_con_md_busy, 1'b0);
        check("reset_done", bus4.o_con_md_done, 1'b0);
        check("reset_stall", bus4.o_con_stall, 1'b0);
        check("reset_start", bus4.o_con_md_start, 1'b0);

        // Full decode sweep
        for (int ao = 0; ao < 4; ao++) begin
            for (int fn = 0; fn < 64; fn++) begin
                for (int ot = 0; ot < 16; ot++) begin
                    bus4.i_con_AluOp    = 2'(ao);
                    bus4.i_con_FuncCode = 6'(fn);
                    bus4.i_con_Other    = 4'(ot);
                    #1;
                    check($sformatf("dec_ao%0d_fn%0d_ot%0d", ao, fn, ot),
                          {bus4.o_con_AluCtrl, bus4.o_con_jumpreg, bus4.o_con_illegal, bus4.o_con_hilo_sel},
                          exp_dec(2'(ao), 6'(fn), 4'(ot)));
                end
            end
        end
        drive4(1'b0, 1'b0, 2'b00, 6'd0);

        // mult launch timing, MD_CYCLES=4
        cyc();
        drive4(1'b1, 1'b0, 2'b10, 6'd24);
        #1;
        check("mult_start", bus4.o_con_md_start, 1'b1);
        check("mult_op", bus4.o_con_md_op, 2'b00);
        check("mult_busy_t0", bus4.o_con_md_busy, 1'b0);
        check("mult_stall_t0", bus4.o_con_stall, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            drive4(1'b0, 1'b0, 2'b00, 6'd0);
            #1;
            check($sformatf("mult_busy_t%0d", k), bus4.o_con_md_busy, 1'b1);
            check($sformatf("mult_nodone_t%0d", k), bus4.o_con_md_done, 1'b0);
            check($sformatf("mult_nostart_t%0d", k), bus4.o_con_md_start, 1'b0);
        end
        cyc();
        #1;
        check("mult_busy_t5", bus4.o_con_md_busy, 1'b0);
        check("mult_done_t5", bus4.o_con_md_done, 1'b1);
        cyc();
        #1;
        check("mult_done_t6", bus4.o_con_md_done, 1'b0);

        // div then mflo: stall until the unit frees up
        drive4(1'b1, 1'b0, 2'b10, 6'd26);
        #1;
        check("div_start", bus4.o_con_md_start, 1'b1);
        check("div_op", bus4.o_con_md_op, 2'b10);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            drive4(1'b1, 1'b0, 2'b10, 6'd18);
            #1;
            check($sformatf("mflo_stall_t%0d", k), bus4.o_con_stall, 1'b1);
            check($sformatf("mflo_hilo_t%0d", k), bus4.o_con_hilo_sel, 2'b10);
            check($sformatf("mflo_nostart_t%0d", k), bus4.o_con_md_start, 1'b0);
        end
        cyc();
        #1;
        check("mflo_stall_t5", bus4.o_con_stall, 1'b0);
        check("mflo_hilo_t5", bus4.o_con_hilo_sel, 2'b10);
        check("div_done_t5", bus4.o_con_md_done, 1'b1);
        drive4(1'b0, 1'b0, 2'b00, 6'd0);

        // divu with flush in IDLE, then flush during RUN
        cyc();
        drive4(1'b1, 1'b1, 2'b10, 6'd27);
        #1;
        check("flush_nostart", bus4.o_con_md_start, 1'b0);
        cyc();
        #1;
        check("flush_nobusy", bus4.o_con_md_busy, 1'b0);
        bus4.i_con_flush = 1'b0;
        #1;
        check("divu_start", bus4.o_con_md_start, 1'b1);
        check("divu_op", bus4.o_con_md_op, 2'b11);
        cyc();
        drive4(1'b1, 1'b1, 2'b10, 6'd27);
        #1;
        check("flush_run_nostall", bus4.o_con_stall, 1'b0);
        check("flush_run_nostart", bus4.o_con_md_start, 1'b0);
        check("flush_run_busy_t1", bus4.o_con_md_busy, 1'b1);
        for (int k = 2; k <= 4; k++) begin
            cyc();
            #1;
            check($sformatf("flush_run_busy_t%0d", k), bus4.o_con_md_busy, 1'b1);
        end
        cyc();
        drive4(1'b0, 1'b0, 2'b00, 6'd0);
        #1;
        check("flush_run_done", bus4.o_con_md_done, 1'b1);
        check("flush_run_idle", bus4.o_con_md_busy, 1'b0);

        // Reset mid-RUN discards the op; a new multu launches right after
        cyc();
        drive4(1'b1, 1'b0, 2'b10, 6'd24);
        #1;
        check("rstrun_start", bus4.o_con_md_start, 1'b1);
        cyc();
        drive4(1'b0, 1'b0, 2'b00, 6'd0);
        cyc();
        rst = 1'b1;
        #1;
        check("rstrun_busy_t2", bus4.o_con_md_busy, 1'b1);
        cyc();
        rst = 1'b0;
        #1;
        check("rstrun_busy_t3", bus4.o_con_md_busy, 1'b0);
        check("rstrun_nodone_t3", bus4.o_con_md_done, 1'b0);
        check("rstrun_nostall_t3", bus4.o_con_stall, 1'b0);
        drive4(1'b1, 1'b0, 2'b10, 6'd25);
        #1;
        check("multu_start", bus4.o_con_md_start, 1'b1);
        check("multu_op", bus4.o_con_md_op, 2'b01);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            drive4(1'b0, 1'b0, 2'b00, 6'd0);
            #1;
            check($sformatf("multu_busy_t%0d", k), bus4.o_con_md_busy, 1'b1);
            check($sformatf("multu_nodone_t%0d", k), bus4.o_con_md_done, 1'b0);
        end
        cyc();
        #1;
        check("multu_done", bus4.o_con_md_done, 1'b1);

        // MD_CYCLES=1: back-to-back mult, multu
        cyc();
        drive1(1'b1, 6'd24);
        #1;
        check("b2b_start_t0", bus1.o_con_md_start, 1'b1);
        check("b2b_op_t0", bus1.o_con_md_op, 2'b00);
        cyc();
        drive1(1'b1, 6'd25);
        #1;
        check("b2b_busy_t1", bus1.o_con_md_busy, 1'b1);
        check("b2b_stall_t1", bus1.o_con_stall, 1'b1);
        check("b2b_nostart_t1", bus1.o_con_md_start, 1'b0);
        cyc();
        #1;
        check("b2b_start_t2", bus1.o_con_md_start, 1'b1);
        check("b2b_op_t2", bus1.o_con_md_op, 2'b01);
        check("b2b_stall_t2", bus1.o_con_stall, 1'b0);
        check("b2b_done_t2", bus1.o_con_md_done, 1'b1);
        cyc();
        drive1(1'b0, 6'd0);
        #1;
        check("b2b_busy_t3", bus1.o_con_md_busy, 1'b1);
        check("b2b_nodone_t3", bus1.o_con_md_done, 1'b0);
        cyc();
        #1;
        check("b2b_busy_t4", bus1.o_con_md_busy, 1'b0);
        check("b2b_done_t4", bus1.o_con_md_done, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_control_mc
`default_nettype wire
